registro_teclas_fifo: RTL and testbench

REGISTRO_TECLAS_FIFO -- requirements
Module: registro_teclas_fifo

---
 rtl/registro_teclas_fifo.sv | 153 +++++++++++++++
 tb/tb_registro_teclas_fifo.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/registro_teclas_fifo.sv
// registro_teclas_fifo
// Scan-code capture register with a make/break decoder and a small
// first-word-fall-through event FIFO.
//
// Handshake: Tecla_valid is a one-cycle strobe with no backpressure; a
// qualifying make code is always registered in Salida_Guardar, and it is
// pushed into the FIFO unless the FIFO is full with no same-cycle pop, in
// which case it is dropped and overflow sets. rd_en pops the head only when
// fifo_empty=0; fifo_dout is valid whenever fifo_empty=0.
module registro_teclas_fifo #(
    parameter int                 DATA_W     = 8,
    parameter int                 DEPTH      = 4,
    parameter int                 MODE       = 0,
    parameter logic [DATA_W-1:0]  MATCH0     = 8'h70,
    parameter logic [DATA_W-1:0]  MATCH1     = 8'h69,
    parameter logic [DATA_W-1:0]  BREAK_CODE = 8'hF0,
    parameter logic [DATA_W-1:0]  IDLE_VAL   = {DATA_W{1'b1}},
    localparam int                AW         = $clog2(DEPTH),
    localparam int                CW         = $clog2(DEPTH) + 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [DATA_W-1:0] Tecla,
    input  logic              Tecla_valid,
    input  logic              clear,
    input  logic              rd_en,
    output logic [DATA_W-1:0] Salida_Guardar,
    output logic [DATA_W-1:0] fifo_dout,
    output logic              fifo_empty,
    output logic              fifo_full,
    output logic [CW-1:0]     count,
    output logic              overflow,
    output logic              fsm_state_dbg
);

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_BREAK = 1'b1
    } state_t;

    state_t            state_q, state_d;
    logic              qualify;

    logic [DATA_W-1:0] sg_q, sg_d;
    logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]     count_q, count_d;
    logic              overflow_q, overflow_d;
    logic [DATA_W-1:0] mem_q [DEPTH];

    logic              do_pop;
    logic              do_push;

    // FSM state register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next state: moves only on a valid code; clear forces IDLE
    always_comb begin
        state_d = state_q;
        if (clear) begin
            state_d = ST_IDLE;
        end else if (Tecla_valid) begin
            case (state_q)
                ST_IDLE:  if (Tecla == BREAK_CODE) state_d = ST_BREAK;
                ST_BREAK: state_d = ST_IDLE;
                default:  state_d = ST_IDLE;
            endcase
        end
    end

    // FSM output: a make code seen in IDLE that matches the capture filter
    always_comb begin
        qualify = 1'b0;
        if (Tecla_valid && !clear && (state_q == ST_IDLE) && (Tecla != BREAK_CODE)) begin
            qualify = (MODE == 1) || (Tecla == MATCH0) || (Tecla == MATCH1);
        end
    end

    // FIFO and capture register next values; a pop frees the slot a full push needs
    always_comb begin
        do_pop     = rd_en && !fifo_empty && !clear;
        do_push    = qualify && (!fifo_full || do_pop);
        sg_d       = sg_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        overflow_d = overflow_q;
        if (clear) begin
            sg_d       = IDLE_VAL;
            wr_ptr_d   = '0;
            rd_ptr_d   = '0;
            count_d    = '0;
            overflow_d = 1'b0;
        end else begin
            if (qualify) begin
                sg_d = Tecla;
            end
            if (qualify && !do_push) begin
                overflow_d = 1'b1;
            end
            if (do_push) begin
                wr_ptr_d = wr_ptr_q + AW'(1);
            end
            if (do_pop) begin
                rd_ptr_d = rd_ptr_q + AW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count_d = count_q + CW'(1);
                2'b01:   count_d = count_q - CW'(1);
                default: count_d = count_q;
            endcase
        end
    end

    // Control state registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sg_q       <= IDLE_VAL;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            sg_q       <= sg_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
        end
    end

    // FIFO storage; contents are meaningless outside the count window so no reset
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= Tecla;
        end
    end

    assign Salida_Guardar = sg_q;
    assign fifo_dout      = mem_q[rd_ptr_q];
    assign count          = count_q;
    assign fifo_empty     = (count_q == '0);
    assign fifo_full      = (count_q == CW'(DEPTH));
    assign overflow       = overflow_q;
    assign fsm_state_dbg  = state_q;

endmodule

// File: tb/tb_registro_teclas_fifo.sv
// Bench for registro_teclas_fifo: one MODE=0 and one MODE=1 instance share
// the same stimulus; a queue-based model predicts both every cycle, and
// directed sequences pin literal values.
module tb_registro_teclas_fifo;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] Tecla;
    logic       Tecla_valid;
    logic       clear;
    logic       rd_en;

    logic [7:0] sg0, dout0, sg1, dout1;
    logic       empty0, full0, ovf0, st0, empty1, full1, ovf1, st1;
    logic [2:0] cnt0, cnt1;

    int checks   = 0;
    int failures = 0;

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    // ---------------- DUTs ----------------
    registro_teclas_fifo #(.MODE(0)) dut0 (
        .clk(clk), .reset(reset), .Tecla(Tecla), .Tecla_valid(Tecla_valid),
        .clear(clear), .rd_en(rd_en), .Salida_Guardar(sg0), .fifo_dout(dout0),
        .fifo_empty(empty0), .fifo_full(full0), .count(cnt0), .overflow(ovf0),
        .fsm_state_dbg(st0)
    );

    registro_teclas_fifo #(.MODE(1)) dut1 (
        .clk(clk), .reset(reset), .Tecla(Tecla), .Tecla_valid(Tecla_valid),
        .clear(clear), .rd_en(rd_en), .Salida_Guardar(sg1), .fifo_dout(dout1),
        .fifo_empty(empty1), .fifo_full(full1), .count(cnt1), .overflow(ovf1),
        .fsm_state_dbg(st1)
    );

    // ---------------- behavioural model ----------------
    logic [7:0] q0[$];
    logic [7:0] q1[$];
    logic [7:0] m_sg0 = 8'hFF;
    logic [7:0] m_sg1 = 8'hFF;
    bit         m_ov0 = 0;
    bit         m_ov1 = 0;
    bit         m_brk = 0;

    function automatic bit wanted(input int mode, input logic [7:0] c);
        return (mode == 1) || (c == 8'h70) || (c == 8'h69);
    endfunction

    always @(posedge clk or negedge reset) begin
        bit pop0, pop1, make;
        logic [7:0] junk;
        if (!reset || clear) begin
            q0.delete(); q1.delete();
            m_sg0 = 8'hFF; m_sg1 = 8'hFF;
            m_ov0 = 0; m_ov1 = 0; m_brk = 0;
        end else begin
            pop0 = rd_en && (q0.size() != 0);
            pop1 = rd_en && (q1.size() != 0);
            make = Tecla_valid && !m_brk && (Tecla != 8'hF0);
            if (pop0) junk = q0.pop_front();
            if (pop1) junk = q1.pop_front();
            if (make && wanted(0, Tecla)) begin
                m_sg0 = Tecla;
                if (q0.size() < 4) q0.push_back(Tecla); else m_ov0 = 1;
            end
            if (make && wanted(1, Tecla)) begin
                m_sg1 = Tecla;
                if (q1.size() < 4) q1.push_back(Tecla); else m_ov1 = 1;
            end
            if (Tecla_valid) m_brk = !m_brk && (Tecla == 8'hF0);
        end
    end

    // ---------------- scoreboard ----------------
    task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    // Per-cycle comparison against the model, away from the active edge
    always @(negedge clk) begin
        cmp("m0_sg",    sg0,    m_sg0);
        cmp("m0_count", cnt0,   q0.size());
        cmp("m0_empty", empty0, q0.size() == 0);
        cmp("m0_full",  full0,  q0.size() == 4);
        cmp("m0_ovf",   ovf0,   m_ov0);
        cmp("m0_state", st0,    m_brk);
        if (q0.size() != 0) cmp("m0_dout", dout0, q0[0]);
        cmp("m1_sg",    sg1,    m_sg1);
        cmp("m1_count", cnt1,   q1.size());
        cmp("m1_empty", empty1, q1.size() == 0);
        cmp("m1_full",  full1,  q1.size() == 4);
        cmp("m1_ovf",   ovf1,   m_ov1);
        cmp("m1_state", st1,    m_brk);
        if (q1.size() != 0) cmp("m1_dout", dout1, q1[0]);
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
        Tecla_valid = 0;
        rd_en       = 0;
        clear       = 0;
    endtask

    task automatic send(input logic [7:0] c);
        Tecla       = c;
        Tecla_valid = 1;
        tick();
    endtask

    task automatic pop();
        rd_en = 1;
        tick();
    endtask

    task automatic do_clear();
        clear = 1;
        tick();
    endtask

    function automatic logic [7:0] pick_code();
        case ($urandom_range(0, 5))
            0:       return 8'h70;
            1:       return 8'h69;
            2:       return 8'hF0;
            3:       return 8'h1C;
            4:       return 8'h32;
            default: return 8'($urandom_range(0, 255));
        endcase
    endfunction

    // ---------------- stimulus ----------------
    initial begin
        reset = 0; Tecla = 0; Tecla_valid = 0; clear = 0; rd_en = 0;
        @(posedge clk);
        @(posedge clk);
        #1;
        reset = 1;

        // reset state
        cmp("rst_sg",    sg0,    8'hFF);
        cmp("rst_count", cnt0,   0);
        cmp("rst_empty", empty0, 1);
        cmp("rst_full",  full0,  0);
        cmp("rst_ovf",   ovf0,   0);
        cmp("rst_state", st0,    0);

        // match capture and non-matching code in MODE 0
        send(8'h70);
        cmp("m70_sg",    sg0,   8'h70);
        cmp("m70_count", cnt0,  1);
        cmp("m70_dout",  dout0, 8'h70);
        send(8'h1C);
        cmp("m1c_sg",    sg0,   8'h70);
        cmp("m1c_count", cnt0,  1);

        // break prefix swallows the next code
        do_clear();
        send(8'hF0);
        cmp("brk_state", st0, 1);
        send(8'h70);
        cmp("brk_sg",    sg0,  8'hFF);
        cmp("brk_count", cnt0, 0);
        cmp("brk_idle",  st0,  0);
        send(8'h70);
        cmp("after_brk_sg",    sg0,  8'h70);
        cmp("after_brk_count", cnt0, 1);

        // overflow in MODE 1
        do_clear();
        send(8'h1C); send(8'h32); send(8'h21); send(8'h23); send(8'h24);
        cmp("ovf_full", full1, 1);
        cmp("ovf_flag", ovf1,  1);
        cmp("ovf_sg",   sg1,   8'h24);
        cmp("pop_a", dout1, 8'h1C); pop();
        cmp("pop_b", dout1, 8'h32); pop();
        cmp("pop_c", dout1, 8'h21); pop();
        cmp("pop_d", dout1, 8'h23); pop();
        cmp("pop_empty", empty1, 1);

        // push and pop on a full FIFO
        do_clear();
        send(8'h1C); send(8'h32); send(8'h21); send(8'h23);
        rd_en = 1;
        send(8'h70);
        cmp("pp_count", cnt1,  4);
        cmp("pp_head",  dout1, 8'h32);
        cmp("pp_ovf",   ovf1,  0);
        pop(); pop(); pop(); pop();
        pop();
        cmp("empty_rd_count", cnt1,   0);
        cmp("empty_rd_empty", empty1, 1);

        // clear beats a coincident valid code
        do_clear();
        send(8'h1C); send(8'h32); send(8'h21); send(8'h23); send(8'h24);
        pop(); pop();
        cmp("pre_clr_count", cnt1, 2);
        send(8'hF0);
        cmp("pre_clr_state", st1, 1);
        clear = 1;
        send(8'h70);
        cmp("clr_count", cnt1, 0);
        cmp("clr_ovf",   ovf1, 0);
        cmp("clr_sg",    sg1,  8'hFF);
        cmp("clr_state", st1,  0);

        // asynchronous reset between edges
        send(8'h1C); send(8'hF0);
        Tecla = 8'h21; Tecla_valid = 1;
        #3 reset = 0;
        #1;
        cmp("areset_count", cnt1,   0);
        cmp("areset_sg",    sg1,    8'hFF);
        cmp("areset_empty", empty1, 1);
        cmp("areset_full",  full1,  0);
        cmp("areset_ovf",   ovf1,   0);
        cmp("areset_state", st1,    0);
        Tecla_valid = 0;
        @(posedge clk);
        #1 reset = 1;
        send(8'h70);
        cmp("post_rst_sg",    sg0,  8'h70);
        cmp("post_rst_count", cnt0, 1);

        // randomized traffic checked by the model each cycle
        for (int i = 0; i < 3000; i++) begin
            Tecla       = pick_code();
            Tecla_valid = ($urandom_range(0, 9) < 6);
            rd_en       = ($urandom_range(0, 9) < 3);
            clear       = ($urandom_range(0, 99) < 3);
            if ($urandom_range(0, 299) == 0) begin
                #3 reset = 0;
                #4 reset = 1;
            end
            tick();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
